// File: rtl/ltc2333_read.sv
// LTC2333 capture side: deserialises both SDO lanes, checks each 24-bit word's
// channel/SoftSpan header and queues tagged results in a FWFT output FIFO.
module ltc2333_read #(
  parameter int CAPTURE_DELAY = 3,
  parameter int FIFO_DEPTH    = 16,
  parameter int NCHAN         = 8
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        clr,
  input  logic        frame_start,
  input  logic [7:0]  active_channels,
  input  logic [2:0]  range,
  input  logic [1:0]  sdo,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_done,
  output logic        hdr_err,
  output logic [15:0] err_count,
  output logic        overflow,
  output logic        busy
);

  localparam int         AW  = $clog2(FIFO_DEPTH);
  localparam logic [7:0] DLY = 8'(CAPTURE_DELAY);

  typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mask_q;
  logic [2:0]        rng_q;
  logic [2:0]        exp_ptr;
  logic [3:0]        words_left;
  logic [7:0]        dly_cnt;
  logic [4:0]        bit_cnt;
  // Only 23 bits are stored: the 24th bit is taken straight from sdo on the
  // completing cycle, so the full word is available without a stall.
  logic [1:0][22:0]  sr;
  logic [1:0][23:0]  word_in;
  logic [1:0]        word_err;
  logic [1:0][23:0]  hold;
  logic [1:0]        hold_err;
  logic              pend0, pend1;
  logic              word_end, done_set;

  logic              push_valid, push_lane, push_err, push_ok, pop, full;
  logic [31:0]       push_word;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [31:0]       mem [FIFO_DEPTH];

  function automatic logic [2:0] first_chan(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NCHAN - 1; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Next set bit after cur, wrapping; a lone (or empty) mask stays put.
  function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] c;
    r = cur;
    for (int i = NCHAN - 1; i >= 1; i--) begin
      c = 3'((int'(cur) + i) % NCHAN);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  function automatic logic [3:0] word_total(input logic [7:0] m);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NCHAN; i++) n = n + 4'(m[i]);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path can leave a value held and infer a latch.
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    word_end  = 1'b0;
    case (state)
      IDLE:    if (frame_start) state_nxt = (CAPTURE_DELAY == 0) ? SHIFT : ALIGN;
      ALIGN:   if (dly_cnt <= 8'd1) state_nxt = SHIFT;
      SHIFT: begin
        word_end = (bit_cnt == 5'd23);
        if (word_end && words_left == 4'd1) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!pend0 && !pend1) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      word_in[k]  = {sr[k], sdo[k]};
      word_err[k] = (word_in[k][5:3] != exp_ptr) || (word_in[k][2:0] != rng_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      mask_q     <= '0;
      rng_q      <= '0;
      exp_ptr    <= '0;
      words_left <= '0;
      dly_cnt    <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      hold       <= '0;
      hold_err   <= '0;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_set;
      pend0      <= word_end;
      pend1      <= pend0;
      if (state == IDLE && frame_start) begin
        mask_q     <= active_channels;
        rng_q      <= range;
        exp_ptr    <= first_chan(active_channels);
        words_left <= word_total(active_channels);
        dly_cnt    <= DLY;
        bit_cnt    <= '0;
      end
      if (state == ALIGN) dly_cnt <= dly_cnt - 8'd1;
      if (state == SHIFT) begin
        for (int k = 0; k < 2; k++) sr[k] <= word_in[k][22:0];
        bit_cnt <= word_end ? 5'd0 : bit_cnt + 5'd1;
        if (word_end) begin
          hold       <= word_in;
          hold_err   <= word_err;
          exp_ptr    <= next_chan(mask_q, exp_ptr);
          words_left <= words_left - 4'd1;
        end
      end
    end
  end

  // Lane 0 goes out the cycle after completion, lane 1 the cycle after that.
  assign push_valid = pend0 | pend1;
  assign push_lane  = pend1;
  assign push_word  = {7'b0, push_lane, hold[push_lane]};
  assign push_err   = push_valid & hold_err[push_lane];

  assign m_valid = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = m_valid & m_ready;
  assign push_ok = push_valid & (~full | pop) & ~clr;
  assign m_data  = m_valid ? mem[rd_ptr[AW-1:0]] : 32'd0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      err_count <= '0;
      hdr_err   <= 1'b0;
    end else begin
      hdr_err <= push_err;
      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        err_count <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (push_valid && full && !pop) overflow <= 1'b1;
        if (push_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; only the pointers do, and m_data is
  // gated by m_valid so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
  end

endmodule

// File: doc/ltc2333_read.md
Name: ltc2333_read

Overview:
- Capture side of the LTC2333 serial interface.
- Deserialises the two SDO lanes, one per ADC, while the control-word writer clocks SCKI.
- Checks each 24-bit result word's channel-ID and SoftSpan header, and queues tagged results in a FIFO on a valid/ready stream toward the DMA/AXI side.
- Sits beside the writer in the same clk domain; the writer's frame start drives frame_start.

Parameters:
- CAPTURE_DELAY, 3, clk cycles from frame_start to the first sdo sample (round-trip SCKI→SDO latency).
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥4.
- NCHAN, 8, ADC channels per device.

Ports:
- clk  in  1  block clock, same as the writer clock.
- areset  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous clear of overflow, err_count and FIFO contents.
- frame_start  in  1  one-cycle pulse: a serial frame begins.
- active_channels  in  8  channel mask; sampled at frame_start.
- range  in  3  expected SoftSpan code; sampled at frame_start.
- sdo  in  2  serial data, lane k from ADC k, MSB first.
- m_data  out  32  {7'b0, lane, result[17:0], chan[2:0], span[2:0]}.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts when m_valid && m_ready.
- frame_done  out  1  one-cycle pulse after the last word of a frame is pushed or dropped.
- hdr_err  out  1  one-cycle pulse per mismatching word.
- err_count  out  16  saturating header-error count.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (areset=1, asynchronous):
  - State returns to IDLE.
  - FIFO is emptied; m_valid=0, m_data=0.
  - frame_done=0, hdr_err=0, err_count=0, overflow=0, busy=0.
  - Shift registers are cleared.
- Reset mid-frame abandons the frame; no partial word is ever pushed.
- States:
  - IDLE: on frame_start, latch active_channels and range.
    - Set n_words to the popcount of the mask, or 1 if the mask is 0 (channel 0 expected).
    - Set the expected-channel pointer to the lowest set bit.
    - Load the delay counter to CAPTURE_DELAY and go to ALIGN.
  - ALIGN: decrement the counter; at 0 go to SHIFT. With CAPTURE_DELAY=0, go straight to SHIFT.
  - SHIFT: each cycle shift sdo[k] into sr[k] (24 bits) and increment bit_cnt (0..23).
    - When bit_cnt=23, both lanes' words complete this cycle.
    - Push lane 0 in the following cycle and lane 1 in the cycle after, using a holding register.
    - Shifting continues without a gap.
    - Advance the expected pointer to the next set bit (wrap modulo NCHAN) and decrement words_left.
    - When words_left reaches 0, go to FLUSH.
  - FLUSH: complete the pending lane pushes, pulse frame_done, return to IDLE.
- Word decode: word[23:6]=result, [5:3]=chan, [2:0]=span.
  - Header error if chan≠expected pointer or span≠latched range; lanes are checked independently.
  - An errored word is still pushed.
  - Each erroring lane pulses hdr_err for one cycle and increments err_count; err_count saturates at 16'hFFFF.
- FIFO:
  - First-word-fall-through; m_data is valid whenever m_valid=1.
  - A push and a pop in the same cycle while full succeeds and does not drop.
  - A push while full without a pop drops the word and sets overflow.
- frame_start outside IDLE is ignored.
- clr has priority over a same-cycle push: the FIFO is emptied and the push is discarded.

Test Plan:
- Mask 8'hFF, range 3'b111, CAPTURE_DELAY=3, m_ready=1, lane k models an ADC returning result=18'h1000·ch+k, correct headers → 16 words in order: lane0 ch0, lane1 ch0, lane0 ch1, …; first m_valid 3+24+1 cycles after frame_start; hdr_err never pulses; one frame_done.
- Mask 8'b0010_0100 → expected channels 2,5,2,5…; 2 words per lane; lane-1 word carrying chan=3 → exactly one hdr_err pulse, err_count=1, word still delivered with chan=3.
- m_ready=0, FIFO_DEPTH=16, two full 8-channel frames (32 words) → first 16 words retained, overflow=1 from the 17th push onward; clr → overflow=0, m_valid=0.
- areset asserted at bit 10 of the third word → all outputs 0 immediately; next frame_start captures a clean frame with no residue from the aborted one.
- frame_start pulsed again during SHIFT → ignored, word count unchanged; mask 8'h00 → one word per lane expected with chan=0.
- m_ready toggling every cycle during an 8-channel frame → no word lost or duplicated; m_data is stable whenever m_valid=1 and m_ready=0.
